// File: rtl/cache_ctrl_nway.sv
// N-way cache miss controller: zero-latency hits, round-robin/invalid-first victim, write-back then line fill.
// Optional build macro CACHE_CTRL_ERR_EN adds malformed-request and illegal-state error reporting.
module cache_ctrl_nway #(
  parameter int WAYS    = 2,
  parameter int WORDS   = 4,
  parameter int MEM_LAT = 2,
  localparam int OFS_W  = $clog2(WORDS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      addr_in,
  input  logic [15:0]      data_in,
  input  logic             rd_in,
  input  logic             wr_in,
  input  logic [WAYS-1:0]  way_hit,
  input  logic [WAYS-1:0]  way_valid,
  input  logic [WAYS-1:0]  way_dirty,
  input  logic             mem_stall,
  output logic [WAYS-1:0]  cache_en,
  output logic             cache_comp,
  output logic             cache_write,
  output logic [OFS_W-1:0] cache_offset,
  output logic [OFS_W-1:0] mem_offset,
  output logic             tag_src,
  output logic             data_src,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [15:0]      addr_out,
  output logic [15:0]      data_out,
  output logic             done,
  output logic             stall,
  output logic             cache_hit,
  output logic             err
);

  localparam int RR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    WB     = 3'd2,
    FILL   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [3:0]      cnt, cnt_nx;
  logic [RR_W-1:0] rr, rr_nx;
  logic [RR_W-1:0] victim, victim_nx;
  logic [RR_W-1:0] sel;
  logic [15:0]     addr_l, data_l;
  logic            wr_l;
  logic            req, hit_any, bad_req, all_valid, sel_dirty;
  logic [WAYS-1:0] victim_oh;
  logic [3:0]      fill_idx;

  function automatic logic [OFS_W-1:0] word_ofs(input logic [3:0] c);
    return {c[OFS_W-2:0], 1'b0};
  endfunction

  assign req       = rd_in | wr_in;
  assign hit_any   = |(way_hit & way_valid);
  assign all_valid = &way_valid;
  assign victim_oh = WAYS'(1) << victim;
  assign fill_idx  = cnt - 4'(MEM_LAT);

`ifdef CACHE_CTRL_ERR_EN
  assign bad_req = req & ((rd_in & wr_in) | addr_in[0]);
`else
  assign bad_req = 1'b0;
`endif

  // Lowest-index invalid way wins; with every way valid the round-robin pointer decides.
  always_comb begin
    sel = rr;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!way_valid[i]) sel = RR_W'(i);
    end
  end

  assign sel_dirty = way_valid[sel] & way_dirty[sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rr     <= '0;
      victim <= '0;
      addr_l <= '0;
      data_l <= '0;
      wr_l   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      rr     <= rr_nx;
      victim <= victim_nx;
      if (state == IDLE) begin
        addr_l <= addr_in;
        data_l <= data_in;
        wr_l   <= wr_in;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    rr_nx        = rr;
    victim_nx    = victim;
    cache_en     = '0;
    cache_comp   = 1'b0;
    cache_write  = 1'b0;
    cache_offset = '0;
    mem_offset   = '0;
    tag_src      = 1'b0;
    data_src     = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    addr_out     = addr_l;
    data_out     = data_l;
    done         = 1'b0;
    stall        = 1'b0;
    cache_hit    = 1'b0;
    err          = 1'b0;

    case (state)
      IDLE: begin
        addr_out     = addr_in;
        data_out     = data_in;
        cache_comp   = 1'b1;
        cache_offset = addr_in[OFS_W-1:0];
        cnt_nx       = '0;
        if (req) cache_en = '1;
        if (bad_req) begin
          err = 1'b1;
        end else if (req) begin
          cache_write = wr_in;
          if (hit_any) begin
            done      = 1'b1;
            cache_hit = 1'b1;
          end else begin
            stall    = 1'b1;
            state_nx = SELECT;
          end
        end
      end

      SELECT: begin
        stall     = 1'b1;
        victim_nx = sel;
        cnt_nx    = '0;
        if (all_valid) rr_nx = (rr == RR_W'(WAYS - 1)) ? '0 : rr + 1'b1;
        state_nx  = sel_dirty ? WB : FILL;
      end

      WB: begin
        stall        = 1'b1;
        cache_en     = victim_oh;
        tag_src      = 1'b1;
        cache_offset = word_ofs(cnt);
        mem_offset   = word_ofs(cnt);
        if (!mem_stall) begin
          mem_wr = 1'b1;
          if (cnt == 4'(WORDS - 1)) begin
            cnt_nx   = '0;
            state_nx = FILL;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end

      // Memory reads run MEM_LAT words ahead of the array writes that consume them.
      FILL: begin
        stall    = 1'b1;
        cache_en = victim_oh;
        if (cnt < 4'(WORDS)) mem_offset = word_ofs(cnt);
        if (cnt >= 4'(MEM_LAT)) begin
          data_src     = 1'b1;
          cache_offset = word_ofs(fill_idx);
        end
        if (!mem_stall) begin
          mem_rd      = (cnt < 4'(WORDS));
          cache_write = (cnt >= 4'(MEM_LAT));
          if (cnt == 4'(WORDS + MEM_LAT - 1)) begin
            cnt_nx   = '0;
            state_nx = DONE;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end

      DONE: begin
        cache_en     = victim_oh;
        cache_comp   = 1'b1;
        cache_write  = wr_l;
        cache_offset = addr_l[OFS_W-1:0];
        done         = 1'b1;
        state_nx     = IDLE;
      end

      default: begin
        state_nx = IDLE;
`ifdef CACHE_CTRL_ERR_EN
        err = 1'b1;
`endif
      end
    endcase

    // Outputs are held quiet for as long as reset is asserted.
    if (rst) begin
      cache_en     = '0;
      cache_comp   = 1'b0;
      cache_write  = 1'b0;
      cache_offset = '0;
      mem_offset   = '0;
      tag_src      = 1'b0;
      data_src     = 1'b0;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      addr_out     = '0;
      data_out     = '0;
      done         = 1'b0;
      stall        = 1'b0;
      cache_hit    = 1'b0;
      err          = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed bench for cache_ctrl_nway (WAYS=4, WORDS=4, MEM_LAT=2); checks hits, clean/dirty misses, stalls, reset, errors.
module tb_cache_ctrl_nway;

  localparam int WAYS    = 4;
  localparam int WORDS   = 4;
  localparam int MEM_LAT = 2;
  localparam int OFS_W   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      addr_in, data_in;
  logic             rd_in, wr_in;
  logic [WAYS-1:0]  way_hit, way_valid, way_dirty;
  logic             mem_stall;
  logic [WAYS-1:0]  cache_en;
  logic             cache_comp, cache_write;
  logic [OFS_W-1:0] cache_offset, mem_offset;
  logic             tag_src, data_src, mem_rd, mem_wr;
  logic [15:0]      addr_out, data_out;
  logic             done, stall, cache_hit, err;
  logic [51:0]      all_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_ctrl_nway #(.WAYS(WAYS), .WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
    .rd_in(rd_in), .wr_in(wr_in), .way_hit(way_hit), .way_valid(way_valid),
    .way_dirty(way_dirty), .mem_stall(mem_stall), .cache_en(cache_en),
    .cache_comp(cache_comp), .cache_write(cache_write), .cache_offset(cache_offset),
    .mem_offset(mem_offset), .tag_src(tag_src), .data_src(data_src),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_out(addr_out), .data_out(data_out),
    .done(done), .stall(stall), .cache_hit(cache_hit), .err(err)
  );

  assign all_out = {cache_en, cache_comp, cache_write, cache_offset, mem_offset, tag_src,
                    data_src, mem_rd, mem_wr, addr_out, data_out, done, stall, cache_hit, err};

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1; rd_in = 1'b1; wr_in = 1'b0; addr_in = 16'h1234; data_in = 16'hBEEF;
    way_hit = '0; way_valid = '0; way_dirty = '0; mem_stall = 1'b0;
    #3;
    checks++;
    if (all_out !== '0) begin errors++; $display("[TB] FAIL reset_zero got %h want 0", all_out); end
    tick;
    checks++;
    if (all_out !== '0) begin errors++; $display("[TB] FAIL reset_zero_edge got %h want 0", all_out); end
    rd_in = 1'b0; rst = 1'b0;
    #1;
    checks++;
    if ({cache_comp, stall, done, cache_en, mem_rd, mem_wr} !== 9'b1_0_0_0000_0_0) begin
      errors++; $display("[TB] FAIL reset_idle got %b want 100000000", {cache_comp, stall, done, cache_en, mem_rd, mem_wr});
    end
    checks++;
    if (addr_out !== 16'h1234) begin errors++; $display("[TB] FAIL idle_bypass got %h want 1234", addr_out); end
  endtask

  task automatic test_hit;
    tick;
    addr_in = 16'h0040; rd_in = 1'b1; way_hit = 4'b0010; way_valid = 4'b0011;
    #1;
    checks++;
    if ({done, cache_hit, stall, cache_en, cache_write} !== 8'b1_1_0_1111_0) begin
      errors++; $display("[TB] FAIL read_hit got %b want 11011110", {done, cache_hit, stall, cache_en, cache_write});
    end
    rd_in = 1'b0; wr_in = 1'b1; data_in = 16'h5A5A;
    #1;
    checks++;
    if ({done, cache_hit, stall, cache_write, data_out} !== {4'b1101, 16'h5A5A}) begin
      errors++; $display("[TB] FAIL write_hit got %b %h want 1101 5a5a", {done, cache_hit, stall, cache_write}, data_out);
    end
    tick;
    checks++;
    if (stall !== 1'b0 || done !== 1'b1) begin
      errors++; $display("[TB] FAIL hit_no_state_change stall=%b done=%b want 0 1", stall, done);
    end
    wr_in = 1'b0; way_hit = '0;
  endtask

  task automatic test_clean_miss;
    int lat, mo, co, wbc, bad_addr;
    lat = 0; mo = 0; co = 0; wbc = 0; bad_addr = 0;
    tick;
    addr_in = 16'h0120; rd_in = 1'b1; way_valid = 4'b0111; way_dirty = '0; way_hit = '0;
    #1;
    checks++;
    if ({stall, done, cache_hit} !== 3'b100) begin
      errors++; $display("[TB] FAIL miss_stall got %b want 100", {stall, done, cache_hit});
    end
    while (done !== 1'b1 && lat < 40) begin
      tick; lat++;
      addr_in = 16'hFFFE;
      #1;
      if (addr_out !== 16'h0120) bad_addr++;
      if (mem_rd === 1'b1) begin
        checks++;
        if (mem_offset !== 3'(2 * mo) || cache_en !== 4'b1000) begin
          errors++; $display("[TB] FAIL clean_memofs got %0d en %b want %0d en 1000", mem_offset, cache_en, 2 * mo);
        end
        mo++;
      end
      if (cache_write === 1'b1 && done !== 1'b1) begin
        checks++;
        if (cache_offset !== 3'(2 * co) || data_src !== 1'b1 || cache_en !== 4'b1000) begin
          errors++; $display("[TB] FAIL clean_fill got ofs %0d src %b want %0d 1", cache_offset, data_src, 2 * co);
        end
        co++;
      end
      if (mem_wr === 1'b1) wbc++;
    end
    checks++;
    if (lat != 8) begin errors++; $display("[TB] FAIL clean_latency got %0d want 8", lat); end
    checks++;
    if (mo != 4 || co != 4 || wbc != 0) begin
      errors++; $display("[TB] FAIL clean_counts got rd %0d wr %0d wb %0d want 4 4 0", mo, co, wbc);
    end
    checks++;
    if (bad_addr != 0) begin errors++; $display("[TB] FAIL addr_latch got %0d bad cycles want 0", bad_addr); end
    checks++;
    if ({stall, cache_hit, cache_comp} !== 3'b001) begin
      errors++; $display("[TB] FAIL done_outputs got %b want 001", {stall, cache_hit, cache_comp});
    end
    rd_in = 1'b0; addr_in = 16'h0000;
  endtask

  task automatic test_dirty_miss;
    int lat, mo, wbc;
    lat = 0; mo = 0; wbc = 0;
    tick;
    addr_in = 16'h0300; rd_in = 1'b1; way_valid = 4'b1111; way_dirty = 4'b0001; way_hit = '0;
    while (done !== 1'b1 && lat < 40) begin
      tick; lat++;
      #1;
      if (mem_wr === 1'b1) begin
        checks++;
        if (cache_en !== 4'b0001 || tag_src !== 1'b1 || mem_offset !== 3'(2 * wbc) ||
            cache_offset !== 3'(2 * wbc) || cache_write !== 1'b0 || mem_rd !== 1'b0) begin
          errors++; $display("[TB] FAIL wb_cycle got en %b tag %b ofs %0d/%0d want 0001 1 %0d", cache_en, tag_src, mem_offset, cache_offset, 2 * wbc);
        end
        wbc++;
      end
      if (mem_rd === 1'b1) begin
        checks++;
        if (mem_offset !== 3'(2 * mo) || cache_en !== 4'b0001 || wbc != 4) begin
          errors++; $display("[TB] FAIL dirty_fill got ofs %0d en %b wb %0d want %0d 0001 4", mem_offset, cache_en, wbc, 2 * mo);
        end
        mo++;
      end
    end
    checks++;
    if (lat != 12 || wbc != 4 || mo != 4) begin
      errors++; $display("[TB] FAIL dirty_latency got lat %0d wb %0d rd %0d want 12 4 4", lat, wbc, mo);
    end
    rd_in = 1'b0; way_dirty = '0;
  endtask

  task automatic test_mem_stall;
    int lat, mo, co;
    lat = 0; mo = 0; co = 0;
    tick;
    addr_in = 16'h0400; rd_in = 1'b1; way_valid = 4'b1111; way_dirty = '0; way_hit = '0;
    while (done !== 1'b1 && lat < 40) begin
      tick; lat++;
      mem_stall = (lat >= 4 && lat <= 6);
      #1;
      if (mem_stall) begin
        checks++;
        if (mem_rd !== 1'b0 || cache_write !== 1'b0 || stall !== 1'b1) begin
          errors++; $display("[TB] FAIL stall_quiet got rd %b wr %b stall %b want 0 0 1", mem_rd, cache_write, stall);
        end
      end
      if (mem_rd === 1'b1) begin
        checks++;
        if (mem_offset !== 3'(2 * mo) || cache_en !== 4'b0010) begin
          errors++; $display("[TB] FAIL stall_memofs got %0d en %b want %0d 0010", mem_offset, cache_en, 2 * mo);
        end
        mo++;
      end
      if (cache_write === 1'b1 && done !== 1'b1) begin
        checks++;
        if (cache_offset !== 3'(2 * co)) begin
          errors++; $display("[TB] FAIL stall_fillofs got %0d want %0d", cache_offset, 2 * co);
        end
        co++;
      end
    end
    mem_stall = 1'b0;
    checks++;
    if (lat != 11 || mo != 4 || co != 4) begin
      errors++; $display("[TB] FAIL stall_latency got lat %0d rd %0d wr %0d want 11 4 4", lat, mo, co);
    end
    rd_in = 1'b0;
  endtask

  task automatic test_reset_mid_fill;
    tick;
    addr_in = 16'h0500; rd_in = 1'b1; way_valid = 4'b0111; way_dirty = '0; way_hit = '0;
    tick; tick; tick;
    #1;
    checks++;
    if (mem_rd !== 1'b1 || mem_offset !== 3'd2) begin
      errors++; $display("[TB] FAIL fill_cycle2 got rd %b ofs %0d want 1 2", mem_rd, mem_offset);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("[TB] FAIL reset_mid_fill got %h want 0", all_out); end
    rd_in = 1'b0;
    tick;
    rst = 1'b0;
    #1;
    checks++;
    if ({stall, mem_rd, cache_comp, done} !== 4'b0010) begin
      errors++; $display("[TB] FAIL after_reset_idle got %b want 0010", {stall, mem_rd, cache_comp, done});
    end
    rd_in = 1'b1; way_hit = 4'b0100;
    #1;
    checks++;
    if ({done, cache_hit, stall} !== 3'b110) begin
      errors++; $display("[TB] FAIL hit_after_reset got %b want 110", {done, cache_hit, stall});
    end
    tick;
    rd_in = 1'b0; way_hit = '0;
  endtask

  task automatic test_rr_after_reset;
    int lat;
    lat = 0;
    tick;
    addr_in = 16'h0600; rd_in = 1'b1; way_valid = 4'b1111; way_dirty = '0; way_hit = '0;
    while (done !== 1'b1 && lat < 40) begin
      tick; lat++;
      #1;
      if (lat == 2) begin
        checks++;
        if (cache_en !== 4'b0001) begin errors++; $display("[TB] FAIL rr_reset_victim got %b want 0001", cache_en); end
      end
    end
    checks++;
    if (lat != 8) begin errors++; $display("[TB] FAIL rr_reset_latency got %0d want 8", lat); end
    rd_in = 1'b0;
  endtask

  task automatic test_err;
    tick;
    rd_in = 1'b1; wr_in = 1'b1; addr_in = 16'h0200; way_hit = 4'b0001; way_valid = 4'b0001;
    #1;
    checks++;
`ifdef CACHE_CTRL_ERR_EN
    if ({err, done, stall} !== 3'b100) begin
      errors++; $display("[TB] FAIL err_rdwr got %b want 100", {err, done, stall});
    end
    wr_in = 1'b0; addr_in = 16'h0201;
    #1;
    checks++;
    if ({err, done, stall} !== 3'b100) begin
      errors++; $display("[TB] FAIL err_odd_addr got %b want 100", {err, done, stall});
    end
`else
    if ({err, done, stall} !== 3'b010) begin
      errors++; $display("[TB] FAIL err_disabled got %b want 010", {err, done, stall});
    end
`endif
    tick;
    rd_in = 1'b0; wr_in = 1'b0; addr_in = 16'h0000; way_hit = '0;
    #1;
    checks++;
    if ({err, stall, done} !== 3'b000) begin
      errors++; $display("[TB] FAIL err_clear got %b want 000", {err, stall, done});
    end
  endtask

  initial begin
    test_reset;
    test_hit;
    test_clean_miss;
    test_dirty_miss;
    test_mem_stall;
    test_reset_mid_fill;
    test_rr_after_reset;
    test_err;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/cache_ctrl_nway.md
CACHE_CTRL_NWAY -- requirements
Module: cache_ctrl_nway

Interface
Parameters (name, default, meaning):
REQ-001 WAYS, 2, associativity; legal values 1, 2, 4.
REQ-002 WORDS, 4, 16-bit words per line; legal values 4, 8; OFS_W = log2(WORDS)+1 is the byte-offset width.
REQ-003 MEM_LAT, 2, cycles from memory read request to data available at the cache data-in mux; legal range 1-4.
Ports (name, direction, width, meaning):
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 addr_in, data_in  in  16  CPU request address and write data; rd_in, wr_in  in  1  CPU read and write strobes.
REQ-007 way_hit, way_valid, way_dirty  in  WAYS  per-way tag-match, valid and dirty flags from the cache arrays.
REQ-008 mem_stall  in  1  memory busy; freezes the miss sequence for that cycle.
REQ-009 cache_en  out  WAYS  one-hot way enable, or all-ones during lookup; cache_comp, cache_write  out  1  array compare and write controls.
REQ-010 cache_offset, mem_offset  out  OFS_W  word offsets; tag_src, data_src  out  1  selects victim tag and memory data.
REQ-011 mem_rd, mem_wr  out  1  memory strobes; addr_out, data_out  out  16  latched or bypassed request.
REQ-012 done, stall, cache_hit, err  out  1  completion, CPU stall, hit indication, error.

Function
REQ-013 States: IDLE, SELECT, WB, FILL, DONE; 4-bit word counter cnt; log2(WAYS)-bit round-robin pointer rr.
REQ-014 IDLE: addr_out/data_out bypass the inputs; cache_en is all-ones when rd_in|wr_in; cache_comp=1; cache_write=wr_in; request is latched every cycle.
REQ-015 Hit (any way_hit&way_valid bit, with rd_in|wr_in): done=1 and cache_hit=1 in the same cycle; no state change; zero-cycle latency.
REQ-016 Miss: stall=1 combinationally; next state SELECT; the latch closes, and latched values drive addr_out/data_out until DONE.
REQ-017 SELECT: victim = lowest-index invalid way; if every way is valid, victim = rr, and rr increments mod WAYS. Next state is WB when the victim is valid and dirty, otherwise FILL.
REQ-018 WB: WORDS cycles; cache_en=victim; cache_comp=0; cache_write=0; tag_src=1; mem_wr=1; cache_offset=mem_offset=2*cnt.
REQ-019 FILL: WORDS+MEM_LAT cycles. mem_rd=1 with mem_offset=2*cnt for cnt<WORDS. The array write (cache_write=1, data_src=1, cache_offset=2*(cnt-MEM_LAT)) occurs for cnt>=MEM_LAT, so requests and writes overlap.
REQ-020 DONE: one cycle; cache_comp=1; cache_write = latched wr; done=1; stall=0; cache_hit=0; next state IDLE; the latch reopens.
REQ-021 mem_stall=1 in WB or FILL holds cnt, deasserts mem_rd/mem_wr and cache_write, and keeps the state.
REQ-022 Total miss latency = 1 (SELECT) + [WORDS if dirty] + WORDS + MEM_LAT + 1 (DONE) cycles, plus stall cycles.
REQ-023 CPU strobes arriving while not in IDLE are ignored; stall stays 1 until DONE.
REQ-024 Illegal encodings of the state register go to IDLE on the next edge.

Reset
REQ-025 rst=1 forces the state to IDLE, and cnt, rr and the latches to 0, immediately and asynchronously; this includes mid-WB and mid-FILL.
REQ-026 Every output is 0 during reset; after release, outputs follow IDLE rules.

Configuration
REQ-027 Macro CACHE_CTRL_ERR_EN. When defined:
- err=1 for one cycle if rd_in&wr_in, or addr_in[0]=1, in IDLE; such a request is not serviced (done=0, stall=0).
- err=1 on any illegal state encoding.
When undefined, err is tied to 0 and no checks are built.

Verification
REQ-028 WAYS=2: read hit on way1 (way_hit=10, way_valid=11) -> done=1 and cache_hit=1 in the same cycle, stall=0.
REQ-029 WAYS=4, WORDS=4, MEM_LAT=2: clean miss, way_valid=0111 -> victim way3; done exactly 8 cycles after the request; mem_offset sequence 0,2,4,6.
REQ-030 WAYS=2: dirty miss, way_valid=11, way_dirty=01, rr=0 -> WB on way0 with mem_wr=1 for 4 cycles, then FILL; done after 12 cycles; rr becomes 1.
REQ-031 Clean miss with mem_stall=1 for 3 cycles during FILL -> done delayed by exactly 3 cycles; offsets not skipped or repeated.
REQ-032 rst asserted in FILL cycle 2 -> all outputs 0 immediately; a subsequent hit is served normally.
REQ-033 With CACHE_CTRL_ERR_EN defined: rd_in=wr_in=1 in IDLE -> err=1, done=0, stall=0; without the macro, err stays 0.
